traffic_generator: RTL and testbench

TRAFFIC_GENERATOR -- requirements
Module: traffic_generator

---
 rtl/traffic_generator_pkg.sv | 43 ++++
 rtl/traffic_generator_fifo.sv | 61 ++++++
 rtl/traffic_generator.sv | 164 ++++++++++++++++
 tb/tb_traffic_generator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_generator_pkg.sv
// Shared NoC definitions: packet field layout, send-FSM state encoding,
// LFSR taps, and helpers for building packets and stepping the LFSR.
package traffic_generator_pkg;

    // Packet field layout (LSB positions and widths)
    localparam int PKT_MOD_LSB = 0;
    localparam int PKT_MOD_W   = 6;
    localparam int PKT_ID_LSB  = 6;
    localparam int PKT_ID_W    = 10;
    localparam int PKT_DST_LSB = 16;
    localparam int PKT_DST_W   = 6;
    localparam int PKT_USED_W  = 22;   // bits above this are always zero

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Send-side handshake states
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } send_state_t;

    // One LFSR step: shift left, feed back XOR of the tapped bits
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

    // Assemble the used portion of a packet from its three fields
    function automatic logic [PKT_USED_W-1:0] make_packet(
        input logic [PKT_DST_W-1:0] dst,
        input logic [PKT_ID_W-1:0]  id,
        input logic [PKT_MOD_W-1:0] src
    );
        logic [PKT_USED_W-1:0] p;
        p = '0;
        p[PKT_DST_LSB +: PKT_DST_W] = dst;
        p[PKT_ID_LSB  +: PKT_ID_W]  = id;
        p[PKT_MOD_LSB +: PKT_MOD_W] = src;
        return p;
    endfunction

endpackage

// File: rtl/traffic_generator_fifo.sv
// gen_fifo: small synchronous source FIFO with full/empty flags.
// Head is presented combinationally on rd_data; push when full and pop when
// empty are ignored.
module gen_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array write port
    // NOTE: storage is not reset; empty/full gate every read, so stale data is never used.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/traffic_generator.sv
// traffic_generator: periodic packet source for one mesh PE. A timer
// generates packets into a 4-entry FIFO; a two-state request/grant FSM
// drains the FIFO to the router local port.
module traffic_generator
    import traffic_generator_pkg::*;
#(
    parameter logic [5:0]  ModuleID    = 6'b000_000,
    parameter int          dataWidth   = 32,
    parameter int          dim         = 4,
    parameter int          INJ_PERIOD  = 8,
    parameter int          NUM_PACKETS = 16,
    parameter int          DEST_MODE   = 0,
    parameter logic [5:0]  DEST_ID     = 6'b000_001,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [dataWidth-1:0] PacketOut,
    input  logic                 DnStrFull,
    output logic                 ReqDnStr,
    input  logic                 GntDnStr,
    output logic [9:0]           SentCount,
    output logic                 Done
);

    localparam int         FIFO_DEPTH = 4;
    localparam logic [9:0] NUM_P      = 10'(NUM_PACKETS);
    localparam int         TW         = $clog2(INJ_PERIOD + 1);
    localparam logic [2:0] DIM_MASK   = 3'(dim - 1);   // dim is a power of 2

    // Generation side
    logic [TW-1:0]        timer;
    logic                 expired;
    logic [9:0]           gen_count;
    logic                 gen_push;
    logic [LFSR_W-1:0]    lfsr;
    logic [5:0]           rand_dst;
    logic [5:0]           dst;
    logic [dataWidth-1:0] fifo_wr_data;

    // FIFO / send side
    logic [dataWidth-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    send_state_t          state_q;
    send_state_t          state_d;
    logic                 load_req;
    logic                 take_gnt;

    // ------------------------------------------------------------------
    // Generation
    // ------------------------------------------------------------------

    // Timer stays at its expired value while the FIFO is full, so the
    // attempt is simply retried every cycle until a slot opens.
    assign expired  = (timer == TW'(INJ_PERIOD - 1));
    assign gen_push = expired && !fifo_full && (gen_count < NUM_P);

    // Destination selection: fixed, or LFSR-derived folded into the mesh
    // NOTE: combinational blocks assign every output first to avoid inferring latches.
    always_comb begin
        rand_dst = {lfsr[5:3] & DIM_MASK, lfsr[2:0] & DIM_MASK};
        if (rand_dst == ModuleID)
            rand_dst = ModuleID ^ 6'b000_001;
        dst = (DEST_MODE == 1) ? rand_dst : DEST_ID;
    end

    // Packet assembly for the FIFO write port; unused upper bits are zero
    always_comb begin
        fifo_wr_data = '0;
        fifo_wr_data[PKT_USED_W-1:0] = make_packet(dst, gen_count, ModuleID);
    end

    // Injection timer, generated-packet counter and destination LFSR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer     <= '0;
            gen_count <= '0;
            lfsr      <= LFSR_SEED;
        end else begin
            if (gen_push)
                timer <= '0;
            else if (!expired)
                timer <= timer + 1'b1;

            if (gen_push) begin
                gen_count <= gen_count + 10'd1;
                if (DEST_MODE == 1)
                    lfsr <= lfsr_next(lfsr);
            end
        end
    end

    gen_fifo #(
        .WIDTH (dataWidth),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (gen_push),
        .wr_data (fifo_wr_data),
        .pop     (take_gnt),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Send FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: request when data is waiting and the router has room;
    // once committed, only a grant ends the request
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!fifo_empty && !DnStrFull) state_d = WAIT_GNT;
            WAIT_GNT: if (GntDnStr)                  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode: launch a request, or accept a grant (ignored in IDLE)
    always_comb begin
        load_req = 1'b0;
        take_gnt = 1'b0;
        case (state_q)
            IDLE:     load_req = !fifo_empty && !DnStrFull;
            WAIT_GNT: take_gnt = GntDnStr;
            default:  ;
        endcase
    end

    // Registered port outputs: request, held packet, sent count and done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ReqDnStr  <= 1'b0;
            PacketOut <= '0;
            SentCount <= '0;
            Done      <= 1'b0;
        end else begin
            if (load_req) begin
                ReqDnStr  <= 1'b1;
                PacketOut <= fifo_head;
            end else if (take_gnt) begin
                ReqDnStr <= 1'b0;
                if (SentCount != NUM_P) begin
                    SentCount <= SentCount + 10'd1;
                    if (SentCount + 10'd1 == NUM_P)
                        Done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_generator.sv
// Self-checking bench for traffic_generator: three configurations (fixed
// short run, fixed long run, random destinations) on one clock and reset.
module tb_traffic_generator;

    logic        clk;
    logic        rst_n;
    logic        full_in [3];
    logic        gnt_in  [3];
    logic [31:0] pkt_o   [3];
    logic        req_o   [3];
    logic [9:0]  sent_o  [3];
    logic        done_o  [3];

    logic [1:0]  sel;
    logic [31:0] m_pkt;
    logic        m_req;
    logic [9:0]  m_sent;
    logic        m_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] log_q [$];

    localparam logic [5:0] B_ID = 6'b010_011;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    traffic_generator #(
        .ModuleID(6'b000_000), .DEST_ID(6'b001_010), .NUM_PACKETS(3),
        .INJ_PERIOD(4), .DEST_MODE(0)
    ) dut_a (
        .clk(clk), .reset(rst_n), .PacketOut(pkt_o[0]), .DnStrFull(full_in[0]),
        .ReqDnStr(req_o[0]), .GntDnStr(gnt_in[0]), .SentCount(sent_o[0]), .Done(done_o[0])
    );

    traffic_generator #(
        .ModuleID(B_ID), .DEST_ID(6'b001_010), .NUM_PACKETS(20),
        .INJ_PERIOD(2), .DEST_MODE(0)
    ) dut_b (
        .clk(clk), .reset(rst_n), .PacketOut(pkt_o[1]), .DnStrFull(full_in[1]),
        .ReqDnStr(req_o[1]), .GntDnStr(gnt_in[1]), .SentCount(sent_o[1]), .Done(done_o[1])
    );

    traffic_generator #(
        .ModuleID(6'b000_000), .NUM_PACKETS(200), .INJ_PERIOD(1),
        .DEST_MODE(1), .LFSR_SEED(16'hACE1)
    ) dut_c (
        .clk(clk), .reset(rst_n), .PacketOut(pkt_o[2]), .DnStrFull(full_in[2]),
        .ReqDnStr(req_o[2]), .GntDnStr(gnt_in[2]), .SentCount(sent_o[2]), .Done(done_o[2])
    );

    // View of the instance currently under test
    always_comb begin
        m_pkt  = pkt_o[sel];
        m_req  = req_o[sel];
        m_sent = sent_o[sel];
        m_done = done_o[sel];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            full_in[i] = 1'b1;
            gnt_in[i]  = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a request on the selected instance
    task automatic wait_req(output int c);
        c = 0;
        while (!m_req && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (!m_req) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got req=0 want req=1 within 300 cycles");
        end
    endtask

    // Grant d cycles after the minimum latency, then expect request to drop
    task automatic grant(input int d);
        repeat (d) @(negedge clk);
        gnt_in[sel] = 1'b1;
        @(negedge clk);
        gnt_in[sel] = 1'b0;
        check("req_low_after_gnt", 32'(m_req), 32'd0);
    endtask

    // Scoreboard consumer: one request, compare against queue head, grant
    task automatic serve(input int d);
        int          c;
        logic [31:0] e;
        wait_req(c);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("sb_pkt", m_pkt, e);
        log_q.push_back(m_pkt);
        grant(d);
    endtask

    function automatic logic [31:0] pkt(input logic [5:0] dst, input int id, input logic [5:0] src);
        return {10'd0, dst, 10'(id), src};
    endfunction

    typedef struct {
        int          delay;
        logic [31:0] pkt;
        logic [9:0]  sent_after;
    } vec_t;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t        tab [3];
        int          c;
        int          viol;
        logic [31:0] held;
        logic [15:0] l;
        int          taps [4];

        tab[0] = '{0, 32'h000A_0000, 10'd1};
        tab[1] = '{1, 32'h000A_0040, 10'd2};
        tab[2] = '{2, 32'h000A_0080, 10'd3};
        taps   = '{16, 14, 13, 11};

        sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            full_in[i] = 1'b1;
            gnt_in[i]  = 1'b0;
        end
        rst_n = 1'b0;
        #12;
        // Reset state of every instance
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            check("rst_req",  32'(m_req),  32'd0);
            check("rst_pkt",  m_pkt,       32'd0);
            check("rst_sent", 32'(m_sent), 32'd0);
            check("rst_done", 32'(m_done), 32'd0);
        end

        // ---- Fixed destination, 3 packets, table driven ----
        sel = 2'd0;
        do_reset();
        full_in[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_req(c);
            check("a_pkt", m_pkt, tab[i].pkt);
            grant(tab[i].delay);
            check("a_sent", 32'(m_sent), 32'(tab[i].sent_after));
        end
        repeat (20) @(negedge clk);
        check("a_done",      32'(m_done), 32'd1);
        check("a_sent_max",  32'(m_sent), 32'd3);
        check("a_no_extra",  32'(m_req),  32'd0);

        // ---- DnStrFull held: FIFO fills to 4, generation stalls ----
        sel = 2'd1;
        do_reset();
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_req) viol++;
        end
        check("stall_req_low",   32'(viol), 32'd0);
        check("stall_fifo_cnt",  32'(dut_b.u_fifo.count), 32'd4);
        check("stall_gen_count", 32'(dut_b.gen_count), 32'd4);

        // ---- Release: IDs 0..3 then generation resumes with 4 ----
        full_in[1] = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(pkt(6'b001_010, i, B_ID));
        for (int i = 0; i < 5; i++) serve(0);
        check("release_sent", 32'(m_sent), 32'd5);

        // ---- DnStrFull rises while waiting for grant: request held ----
        exp_q.push_back(pkt(6'b001_010, 5, B_ID));
        wait_req(c);
        held = exp_q.pop_front();
        check("hold_first", m_pkt, held);
        full_in[1] = 1'b1;
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            if (!m_req || m_pkt !== held) viol++;
        end
        check("hold_stable", 32'(viol), 32'd0);
        grant(0);
        check("hold_sent", 32'(m_sent), 32'd6);
        full_in[1] = 1'b0;

        // ---- Reset mid WAIT_GNT: abandon, restart at PacketID 0 ----
        exp_q.push_back(pkt(6'b001_010, 6, B_ID));
        wait_req(c);
        check("pre_rst_pkt", m_pkt, exp_q.pop_front());
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req",  32'(m_req),  32'd0);
        check("midrst_sent", 32'(m_sent), 32'd0);
        check("midrst_pkt",  m_pkt,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_req(c);
        check("first_req_latency", 32'(c), 32'd3);

        // ---- Back-to-back with an always-ready collector ----
        log_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(pkt(6'b001_010, i, B_ID));
        for (int i = 0; i < 20; i++) serve(0);
        viol = 0;
        foreach (log_q[i])
            if (log_q[i][15:6] != 10'(i) || log_q[i][5:0] != B_ID) viol++;
        check("collector_log", 32'(viol), 32'd0);
        repeat (10) @(negedge clk);
        check("b_done",     32'(m_done), 32'd1);
        check("b_sent_max", 32'(m_sent), 32'd20);
        check("b_no_extra", 32'(m_req),  32'd0);

        // ---- Random destinations against a reference LFSR ----
        sel = 2'd2;
        do_reset();
        full_in[2] = 1'b0;
        exp_q.delete();
        log_q.delete();
        l = 16'hACE1;
        for (int i = 0; i < 200; i++) begin
            logic [2:0] x;
            logic [2:0] y;
            logic [5:0] d;
            logic       fb;
            x = l[5:3] % 3'd4;
            y = l[2:0] % 3'd4;
            d = {x, y};
            if (d == 6'd0) d = 6'd1;
            exp_q.push_back(pkt(d, i, 6'd0));
            fb = 1'b0;
            for (int k = 0; k < 4; k++) fb = fb ^ l[taps[k] - 1];
            l = {l[14:0], fb};
        end
        for (int i = 0; i < 200; i++) serve(0);
        viol = 0;
        foreach (log_q[i])
            if (log_q[i][21:19] >= 3'd4 || log_q[i][18:16] >= 3'd4 || log_q[i][21:16] == 6'd0)
                viol++;
        check("rand_dst_range", 32'(viol), 32'd0);
        repeat (5) @(negedge clk);
        check("c_done", 32'(m_done), 32'd1);
        check("c_sent", 32'(m_sent), 32'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
